// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined carry-lookahead subtractor, diff = a - b - bin,
// with valid/ready on both sides. Define CLA_SUB_OVF_EN to add the signed-overflow output.

// One half-width CLA subtract slice: a + ~b + ~bin using 4-bit group P/G and
// full lookahead across groups.
module cla_sub_half #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int NG = (W + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] p;
  logic [NP-1:0] g;
  logic [NG-1:0] gp;
  logic [NG-1:0] gg;
  logic [NG:0]   cg;
  logic [NP:0]   c;

  // Pad bits above W carry p=g=0, so a partial top group never alters the real carries.
  always_comb begin
    p = NP'(a) ^ NP'(~b);
    g = NP'(a) & NP'(~b);
  end

  always_comb begin
    gp = '0;
    gg = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Group carries as sum-of-products over all lower groups, not a chained recurrence.
  always_comb begin
    logic term;
    // NOTE: every combinational output gets a default before any loop or branch so no latch is inferred.
    cg    = '0;
    term  = 1'b0;
    cg[0] = ~bin;
    for (int k = 1; k <= NG; k++) begin
      term = ~bin;
      for (int m = 0; m < k; m++) term = term & gp[m];
      cg[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        cg[k] = cg[k] | term;
      end
    end
  end

  always_comb begin
    logic term;
    c    = '0;
    term = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        term = cg[k];
        for (int m = 0; m < i; m++) term = term & p[4*k+m];
        c[4*k+i] = term;
        for (int j = 0; j < i; j++) begin
          term = g[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & p[4*k+m];
          c[4*k+i] = c[4*k+i] | term;
        end
      end
    end
    c[NP] = cg[NG];
  end

  assign diff = W'(p ^ c[NP-1:0]);
  assign bout = ~c[W];

endmodule

module cla_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int H = WIDTH / 2;

  logic         s1_valid;
  logic [H-1:0] s1_lo;
  logic         s1_br;
  logic [H-1:0] s1_a_hi;
  logic [H-1:0] s1_b_hi;
`ifdef CLA_SUB_OVF_EN
  logic         s1_a_sign;
  logic         s1_b_sign;
`endif

  logic [H-1:0] lo_diff;
  logic         lo_bout;
  logic [H-1:0] hi_diff;
  logic         hi_bout;
  logic         s2_free;
  logic         accept;
  logic         xfer;

  // The only combinational path through the block is out_ready -> in_ready.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign xfer     = s1_valid && s2_free;

  cla_sub_half #(.W(H)) u_lo (
    .a    (a[H-1:0]),
    .b    (b[H-1:0]),
    .bin  (bin),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  cla_sub_half #(.W(H)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .bin  (s1_br),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_br     <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
`ifdef CLA_SUB_OVF_EN
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
      ovf       <= 1'b0;
`endif
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_lo     <= lo_diff;
        s1_br     <= lo_bout;
        s1_a_hi   <= a[WIDTH-1:H];
        s1_b_hi   <= b[WIDTH-1:H];
`ifdef CLA_SUB_OVF_EN
        s1_a_sign <= a[WIDTH-1];
        s1_b_sign <= b[WIDTH-1];
`endif
      end else if (xfer) begin
        s1_valid <= 1'b0;
      end

      // Outputs change only on transfer, so a stalled result stays bit-stable.
      if (xfer) begin
        out_valid <= 1'b1;
        diff      <= {hi_diff, s1_lo};
        bout      <= hi_bout;
        zero      <= ~|{hi_diff, s1_lo};
`ifdef CLA_SUB_OVF_EN
        ovf       <= (s1_a_sign != s1_b_sign) && (hi_diff[H-1] != s1_a_sign);
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Testbench for cla_sub_pipe: directed test-plan vectors plus randomized traffic,
// scored against an arithmetic reference model through an in-order queue.
module tb_cla_sub_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
`ifdef CLA_SUB_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
`ifdef CLA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Reference: plain wide arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t r;
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned ub;
    ux = 64'(x);
    uy = 64'(y);
    ub = 64'(bi);
    r.diff = W'(ux - uy - ub);
    r.bout = (ux < uy + ub);
    r.zero = (r.diff == '0);
    r.ovf  = (x[W-1] != y[W-1]) && (r.diff[W-1] != x[W-1]);
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.diff = diff;
    r.bout = bout;
    r.zero = zero;
`ifdef CLA_SUB_OVF_EN
    r.ovf  = ovf;
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    bin      = bi;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h0001_0000;
      5:       v = 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Stimulus side of the scoreboard: every accepted beat pushes its expected result.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(a, b, bin));
  end

  // Monitor: pops on each consumed result, and checks hold stability across stalls.
  res_t held;
  logic stalled = 1'b0;
  always @(negedge clk) begin
    res_t e;
    res_t cur;
    cur = cur_out();
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(cur), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got diff %0h with no beat outstanding", diff);
        end else begin
          e = sb.pop_front();
          check("sb_diff", 64'(diff), 64'(e.diff));
          check("sb_bout", 64'(bout), 64'(e.bout));
          check("sb_zero", 64'(zero), 64'(e.zero));
`ifdef CLA_SUB_OVF_EN
          check("sb_ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
`ifdef CLA_SUB_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Basic: result two edges after the beat is presented
    out_ready = 1'b1;
    drive(32'd5, 32'd3, 1'b0);
    tick();
    idle();
    check("basic_lat_edge1", 64'(out_valid), 64'd0);
    tick();
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_diff", 64'(diff), 64'd2);
    check("basic_bout", 64'(bout), 64'd0);
    check("basic_zero", 64'(zero), 64'd0);
`ifdef CLA_SUB_OVF_EN
    check("basic_ovf", 64'(ovf), 64'd0);
`endif
    tick();

    // Wrap with borrow, then equal operands on the next cycle
    drive(32'd0, 32'd1, 1'b0);
    tick();
    drive(32'd7, 32'd7, 1'b0);
    tick();
    idle();
    check("wrap_valid", 64'(out_valid), 64'd1);
    check("wrap_diff", 64'(diff), 64'hFFFF_FFFF);
    check("wrap_bout", 64'(bout), 64'd1);
    check("wrap_zero", 64'(zero), 64'd0);
    tick();
    check("eq_valid", 64'(out_valid), 64'd1);
    check("eq_diff", 64'(diff), 64'd0);
    check("eq_zero", 64'(zero), 64'd1);
    check("eq_bout", 64'(bout), 64'd0);
    tick();

    // Borrow across the half boundary
    drive(32'h0001_0000, 32'd0, 1'b1);
    tick();
    idle();
    tick();
    check("half_diff", 64'(diff), 64'h0000_FFFF);
    check("half_bout", 64'(bout), 64'd0);
    tick();

`ifdef CLA_SUB_OVF_EN
    drive(32'h8000_0000, 32'd1, 1'b0);
    tick();
    drive(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    idle();
    check("ovf1_diff", 64'(diff), 64'h7FFF_FFFF);
    check("ovf1_ovf", 64'(ovf), 64'd1);
    check("ovf1_bout", 64'(bout), 64'd0);
    tick();
    check("ovf2_diff", 64'(diff), 64'h8000_0000);
    check("ovf2_ovf", 64'(ovf), 64'd1);
    check("ovf2_bout", 64'(bout), 64'd1);
    tick();
`endif

    // Backpressure: fill both stages, stall four cycles, release
    out_ready = 1'b0;
    drive(32'd10, 32'd1, 1'b0);
    tick();
    check("bp_ready_after1", 64'(in_ready), 64'd1);
    drive(32'd20, 32'd2, 1'b0);
    tick();
    drive(32'd30, 32'd3, 1'b0);
    check("bp_ready_full", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_diff_c2", 64'(diff), 64'd9);
    tick();
    check("bp_ready_c3", 64'(in_ready), 64'd0);
    check("bp_diff_c3", 64'(diff), 64'd9);
    tick();
    check("bp_ready_c4", 64'(in_ready), 64'd0);
    check("bp_diff_c4", 64'(diff), 64'd9);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    check("bp_r2_valid", 64'(out_valid), 64'd1);
    check("bp_r2_diff", 64'(diff), 64'd18);
    tick();
    check("bp_r3_valid", 64'(out_valid), 64'd1);
    check("bp_r3_diff", 64'(diff), 64'd27);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset mid-stream with two beats in flight
    drive(32'd100, 32'd1, 1'b0);
    tick();
    drive(32'd200, 32'd2, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_diff", 64'(diff), 64'd0);
    check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
    drive(32'd4, 32'd4, 1'b0);
    tick();
    idle();
    check("post_rst_lat_edge1", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_diff", 64'(diff), 64'd0);
    check("post_rst_zero", 64'(zero), 64'd1);
    tick();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Drain and confirm nothing was lost
    idle();
    out_ready = 1'b1;
    repeat (6) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
